// File: rtl/xdma_cfg_frame_parser.sv
// Parses xDMA config frames into a header descriptor and a payload stream.
// Ports: clk_i/rst_i, in_* frame beats, hdr_* descriptor, pld_* payload, busy_o, err_zero_len_o.
module xdma_cfg_frame_parser #(
  parameter int unsigned DataWidth     = 512,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned FrameLenWidth = 4,
  parameter int unsigned PldWidth      = DataWidth - 1 - FrameLenWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DataWidth-1:0]     in_data_i,
  output logic                     hdr_valid_o,
  input  logic                     hdr_ready_i,
  output logic                     hdr_dma_type_o,
  output logic [IdWidth-1:0]       hdr_dma_id_o,
  output logic [AddrWidth-1:0]     hdr_reader_addr_o,
  output logic [AddrWidth-1:0]     hdr_writer_addr_o,
  output logic [FrameLenWidth-1:0] hdr_frame_len_o,
  output logic                     pld_valid_o,
  input  logic                     pld_ready_i,
  output logic [PldWidth-1:0]      pld_data_o,
  output logic                     pld_first_o,
  output logic                     pld_last_o,
  output logic                     busy_o,
  output logic                     err_zero_len_o
);

  localparam int unsigned LenLsb  = 1;
  localparam int unsigned IdLsb   = LenLsb + FrameLenWidth;
  localparam int unsigned RdLsb   = IdLsb + IdWidth;
  localparam int unsigned WrLsb   = RdLsb + AddrWidth;
  localparam int unsigned HdrBits = WrLsb + AddrWidth;
  localparam int unsigned FirstPw = DataWidth - HdrBits;

  typedef enum logic {IDLE, BODY} state_e;

  state_e                   state_q, state_d;
  logic [FrameLenWidth-1:0] rem_q, rem_d;

  logic                     hdr_valid_q, hdr_valid_d;
  logic                     hdr_type_q, hdr_type_d;
  logic [IdWidth-1:0]       hdr_id_q, hdr_id_d;
  logic [AddrWidth-1:0]     hdr_rd_q, hdr_rd_d;
  logic [AddrWidth-1:0]     hdr_wr_q, hdr_wr_d;
  logic [FrameLenWidth-1:0] hdr_len_q, hdr_len_d;

  logic                     pld_valid_q, pld_valid_d;
  logic [PldWidth-1:0]      pld_data_q, pld_data_d;
  logic                     pld_first_q, pld_first_d;
  logic                     pld_last_q, pld_last_d;
  logic                     err_q, err_d;

  logic                     hdr_free, pld_free, accept;
  logic [FrameLenWidth-1:0] len_fld, eff_len;

  assign hdr_free = !hdr_valid_q || hdr_ready_i;
  assign pld_free = !pld_valid_q || pld_ready_i;

  assign in_ready_o = (state_q == IDLE) ? (pld_free && hdr_free)
                                        : pld_free;
  assign accept = in_valid_i && in_ready_o;

  assign len_fld = in_data_i[LenLsb +: FrameLenWidth];
  // A zero length field is treated as a single-frame config.
  assign eff_len = (len_fld == '0) ? FrameLenWidth'(1) : len_fld;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    hdr_valid_d = hdr_valid_q && !hdr_ready_i;
    hdr_type_d  = hdr_type_q;
    hdr_id_d    = hdr_id_q;
    hdr_rd_d    = hdr_rd_q;
    hdr_wr_d    = hdr_wr_q;
    hdr_len_d   = hdr_len_q;
    pld_valid_d = pld_valid_q && !pld_ready_i;
    pld_data_d  = pld_data_q;
    pld_first_d = pld_first_q;
    pld_last_d  = pld_last_q;
    err_d       = 1'b0;

    if (accept) begin
      pld_valid_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          hdr_valid_d = 1'b1;
          hdr_type_d  = in_data_i[0];
          hdr_id_d    = in_data_i[IdLsb +: IdWidth];
          hdr_rd_d    = in_data_i[RdLsb +: AddrWidth];
          hdr_wr_d    = in_data_i[WrLsb +: AddrWidth];
          hdr_len_d   = eff_len;
          pld_data_d  = {{(PldWidth-FirstPw){1'b0}},
                         in_data_i[DataWidth-1:HdrBits]};
          pld_first_d = 1'b1;
          pld_last_d  = (eff_len == FrameLenWidth'(1));
          err_d       = (len_fld == '0);
          if (eff_len != FrameLenWidth'(1)) begin
            state_d = BODY;
            rem_d   = eff_len - FrameLenWidth'(1);
          end
        end
        BODY: begin
          pld_data_d  = in_data_i[DataWidth-1:LenLsb+FrameLenWidth];
          pld_first_d = 1'b0;
          pld_last_d  = (rem_q == FrameLenWidth'(1));
          rem_d       = rem_q - FrameLenWidth'(1);
          if (rem_q == FrameLenWidth'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      hdr_valid_q <= 1'b0;
      hdr_type_q  <= 1'b0;
      hdr_id_q    <= '0;
      hdr_rd_q    <= '0;
      hdr_wr_q    <= '0;
      hdr_len_q   <= '0;
      pld_valid_q <= 1'b0;
      pld_data_q  <= '0;
      pld_first_q <= 1'b0;
      pld_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_type_q  <= hdr_type_d;
      hdr_id_q    <= hdr_id_d;
      hdr_rd_q    <= hdr_rd_d;
      hdr_wr_q    <= hdr_wr_d;
      hdr_len_q   <= hdr_len_d;
      pld_valid_q <= pld_valid_d;
      pld_data_q  <= pld_data_d;
      pld_first_q <= pld_first_d;
      pld_last_q  <= pld_last_d;
      err_q       <= err_d;
    end
  end

  assign hdr_valid_o       = hdr_valid_q;
  assign hdr_dma_type_o    = hdr_type_q;
  assign hdr_dma_id_o      = hdr_id_q;
  assign hdr_reader_addr_o = hdr_rd_q;
  assign hdr_writer_addr_o = hdr_wr_q;
  assign hdr_frame_len_o   = hdr_len_q;
  assign pld_valid_o       = pld_valid_q;
  assign pld_data_o        = pld_data_q;
  assign pld_first_o       = pld_first_q;
  assign pld_last_o        = pld_last_q;
  assign busy_o            = (state_q == BODY);
  assign err_zero_len_o    = err_q;

endmodule

// File: tb/tb_xdma_cfg_frame_parser.sv
// Directed self-checking bench for xdma_cfg_frame_parser.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_xdma_cfg_frame_parser;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic         hdr_valid;
  logic         hdr_ready;
  logic         hdr_type;
  logic [3:0]   hdr_id;
  logic [47:0]  hdr_rd;
  logic [47:0]  hdr_wr;
  logic [3:0]   hdr_len;
  logic         pld_valid;
  logic         pld_ready;
  logic [506:0] pld_data;
  logic         pld_first;
  logic         pld_last;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xdma_cfg_frame_parser dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_data_i        (in_data),
    .hdr_valid_o      (hdr_valid),
    .hdr_ready_i      (hdr_ready),
    .hdr_dma_type_o   (hdr_type),
    .hdr_dma_id_o     (hdr_id),
    .hdr_reader_addr_o(hdr_rd),
    .hdr_writer_addr_o(hdr_wr),
    .hdr_frame_len_o  (hdr_len),
    .pld_valid_o      (pld_valid),
    .pld_ready_i      (pld_ready),
    .pld_data_o       (pld_data),
    .pld_first_o      (pld_first),
    .pld_last_o       (pld_last),
    .busy_o           (busy),
    .err_zero_len_o   (err)
  );

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] first_f(
      input logic t, input logic [3:0] len, input logic [3:0] id,
      input logic [47:0] rd, input logic [47:0] wr,
      input logic [406:0] pld);
    logic [511:0] f;
    f = '0;
    f[0] = t;
    f[4:1] = len;
    f[8:5] = id;
    f[56:9] = rd;
    f[104:57] = wr;
    f[511:105] = pld;
    return f;
  endfunction

  // Low five bits carry junk that the parser must ignore.
  function automatic logic [511:0] cont_f(input logic [506:0] pld);
    return {pld, 5'b10101};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  logic [506:0] p1, p2, p3, ca, cb;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    p1 = {1'b1, 490'd0, 16'hBEEF};
    p2 = {4'hA, 487'd0, 16'h1234};
    p3 = {2'b11, 489'd0, 16'h5A5A};
    ca = 507'h0CA0;
    cb = {1'b1, 506'h0CB0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    hdr_ready = 1'b1;
    pld_ready = 1'b1;
    step();
    step();
    chk("rst_hdr_valid", 512'(hdr_valid), 512'd0);
    chk("rst_pld_valid", 512'(pld_valid), 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_err", 512'(err), 512'd0);
    chk("rst_pld_data", 512'(pld_data), 512'd0);
    rst = 1'b0;

    // Single-frame config
    in_valid = 1'b1;
    in_data = first_f(1'b1, 4'd1, 4'd3, 48'h1000, 48'h2000, 407'hABC);
    #1 chk("s1_in_ready", 512'(in_ready), 512'd1);
    step();
    in_valid = 1'b0;
    chk("s1_hdr_valid", 512'(hdr_valid), 512'd1);
    chk("s1_type", 512'(hdr_type), 512'd1);
    chk("s1_id", 512'(hdr_id), 512'd3);
    chk("s1_rd", 512'(hdr_rd), 512'h1000);
    chk("s1_wr", 512'(hdr_wr), 512'h2000);
    chk("s1_len", 512'(hdr_len), 512'd1);
    chk("s1_pld_valid", 512'(pld_valid), 512'd1);
    chk("s1_first", 512'(pld_first), 512'd1);
    chk("s1_last", 512'(pld_last), 512'd1);
    chk("s1_data", 512'(pld_data), 512'hABC);
    chk("s1_busy", 512'(busy), 512'd0);
    step();
    chk("s1_drain_pld", 512'(pld_valid), 512'd0);
    chk("s1_drain_hdr", 512'(hdr_valid), 512'd0);

    // Three-frame config at full rate
    in_valid = 1'b1;
    in_data = first_f(1'b0, 4'd3, 4'd5, 48'hABCD_0000_1111,
                      48'h0000_FFFF_2222, 407'h11);
    step();
    chk("m3_f0_first", 512'(pld_first), 512'd1);
    chk("m3_f0_last", 512'(pld_last), 512'd0);
    chk("m3_f0_data", 512'(pld_data), 512'h11);
    chk("m3_f0_busy", 512'(busy), 512'd1);
    chk("m3_len", 512'(hdr_len), 512'd3);
    chk("m3_rd", 512'(hdr_rd), 512'hABCD_0000_1111);
    chk("m3_wr", 512'(hdr_wr), 512'h0000_FFFF_2222);
    in_data = cont_f(p1);
    step();
    chk("m3_f1_first", 512'(pld_first), 512'd0);
    chk("m3_f1_last", 512'(pld_last), 512'd0);
    chk("m3_f1_data", 512'(pld_data), 512'(p1));
    chk("m3_f1_busy", 512'(busy), 512'd1);
    chk("m3_f1_hdr", 512'(hdr_valid), 512'd0);
    in_data = cont_f(p2);
    step();
    in_valid = 1'b0;
    chk("m3_f2_first", 512'(pld_first), 512'd0);
    chk("m3_f2_last", 512'(pld_last), 512'd1);
    chk("m3_f2_data", 512'(pld_data), 512'(p2));
    chk("m3_f2_busy", 512'(busy), 512'd0);
    step();

    // Payload backpressure during a two-frame config
    in_valid = 1'b1;
    in_data = first_f(1'b1, 4'd2, 4'd9, 48'h3, 48'h4, 407'h22);
    pld_ready = 1'b0;
    step();
    in_data = cont_f(p3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 512'(in_ready), 512'd0);
      chk("bp_pld_data", 512'(pld_data), 512'h22);
      chk("bp_pld_first", 512'(pld_first), 512'd1);
      step();
    end
    pld_ready = 1'b1;
    #1 chk("bp_release_ready", 512'(in_ready), 512'd1);
    step();
    in_valid = 1'b0;
    chk("bp_f1_data", 512'(pld_data), 512'(p3));
    chk("bp_f1_last", 512'(pld_last), 512'd1);
    chk("bp_f1_first", 512'(pld_first), 512'd0);
    step();
    chk("bp_no_dup", 512'(pld_valid), 512'd0);

    // Header stall across back-to-back configs
    hdr_ready = 1'b0;
    in_valid = 1'b1;
    in_data = first_f(1'b0, 4'd2, 4'd1, 48'hA, 48'hB, 407'h31);
    step();
    chk("hs_a_id", 512'(hdr_id), 512'd1);
    in_data = cont_f(ca);
    #1 chk("hs_cont_ready", 512'(in_ready), 512'd1);
    step();
    chk("hs_ca_data", 512'(pld_data), 512'(ca));
    chk("hs_ca_last", 512'(pld_last), 512'd1);
    in_data = first_f(1'b1, 4'd2, 4'd2, 48'hC, 48'hD, 407'h41);
    #1 chk("hs_b_blocked", 512'(in_ready), 512'd0);
    step();
    chk("hs_b_blocked2", 512'(in_ready), 512'd0);
    chk("hs_hdr_hold", 512'(hdr_id), 512'd1);
    chk("hs_hdr_valid", 512'(hdr_valid), 512'd1);
    hdr_ready = 1'b1;
    #1 chk("hs_b_ready", 512'(in_ready), 512'd1);
    step();
    chk("hs_b_id", 512'(hdr_id), 512'd2);
    chk("hs_b_first", 512'(pld_first), 512'd1);
    chk("hs_b_data", 512'(pld_data), 512'h41);
    in_data = cont_f(cb);
    step();
    in_valid = 1'b0;
    chk("hs_cb_data", 512'(pld_data), 512'(cb));
    chk("hs_cb_last", 512'(pld_last), 512'd1);
    step();

    // Zero length field
    in_valid = 1'b1;
    in_data = first_f(1'b0, 4'd0, 4'd6, 48'h5, 48'h6, 407'h55);
    step();
    in_valid = 1'b0;
    chk("zl_err", 512'(err), 512'd1);
    chk("zl_len", 512'(hdr_len), 512'd1);
    chk("zl_last", 512'(pld_last), 512'd1);
    chk("zl_busy", 512'(busy), 512'd0);
    step();
    chk("zl_err_pulse", 512'(err), 512'd0);

    // Reset in the middle of a four-frame config
    in_valid = 1'b1;
    in_data = first_f(1'b1, 4'd4, 4'd8, 48'h7, 48'h8, 407'h66);
    step();
    in_valid = 1'b0;
    chk("rm_busy_pre", 512'(busy), 512'd1);
    rst = 1'b1;
    #1;
    chk("rm_hdr_valid", 512'(hdr_valid), 512'd0);
    chk("rm_pld_valid", 512'(pld_valid), 512'd0);
    chk("rm_busy", 512'(busy), 512'd0);
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = first_f(1'b0, 4'd1, 4'd7, 48'h9, 48'hA, 407'h77);
    step();
    in_valid = 1'b0;
    chk("rm_new_id", 512'(hdr_id), 512'd7);
    chk("rm_new_first", 512'(pld_first), 512'd1);
    chk("rm_new_last", 512'(pld_last), 512'd1);
    chk("rm_new_data", 512'(pld_data), 512'h77);
    chk("rm_new_busy", 512'(busy), 512'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
